// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue-stage scoreboard: latency-class encodings
// (also used by the decoder) and small operand-match helpers.
package issue_scoreboard_pkg;

    // Latency class of an issuing instruction; DIV has no fixed length.
    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_DIV  = 2'd3
    } lat_cls_e;

    localparam int NUM_REGS = 32;

    function automatic logic reads_reg(input logic use_r, input logic [4:0] idx,
                                       input logic [4:0] r);
        return use_r && (idx == r);
    endfunction

    function automatic logic src_busy(input logic use_r, input logic [4:0] idx,
                                      input logic [NUM_REGS-1:0] bv);
        return use_r && (idx != 5'd0) && bv[idx];
    endfunction

    // MUL and DIV share a single execution unit.
    function automatic logic is_muldiv(input logic [1:0] lat);
        return lat[1];
    endfunction

endpackage

// File: rtl/issue_scoreboard_sb_entry.sv
// One scoreboard entry: tracks a pending producer of a single register,
// either as a fixed countdown (LOAD/MUL) or as an open-ended DIV.
module sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             wr_en,
    input  logic             wr_busy,
    input  logic             wr_long,
    input  logic [CNT_W-1:0] wr_cnt,
    input  logic             dec_en,
    input  logic             div_clr,
    output logic             busy
);

    logic [CNT_W-1:0] cnt;
    logic             is_long;

    // Priority: reset, flush, new producer (incl. ALU overwrite), then completion.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy    <= 1'b0;
            cnt     <= '0;
            is_long <= 1'b0;
        end else if (flush) begin
            busy    <= 1'b0;
            cnt     <= '0;
            is_long <= 1'b0;
        end else if (wr_en) begin
            busy    <= wr_busy;
            cnt     <= (wr_busy && !wr_long) ? wr_cnt : '0;
            is_long <= wr_busy && wr_long;
        end else if (div_clr) begin
            busy    <= 1'b0;
            cnt     <= '0;
            is_long <= 1'b0;
        end else if (dec_en && busy && !is_long) begin
            // Clearing on the 1->0 step lets the consumer issue as soon as the bypass has the value.
            if (cnt <= CNT_W'(1)) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard tracker for the dual-issue pipeline: holds or splits the
// issue pair until every source is forwardable, and tracks LOAD/MUL/DIV producers.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int LAT_LOAD = 1,
    parameter int LAT_MUL  = 2,
    parameter int CNT_W    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        pipe_stall,
    input  logic        valid0,
    input  logic        valid1,
    input  logic [4:0]  rj0,
    input  logic [4:0]  rj1,
    input  logic [4:0]  rk0,
    input  logic [4:0]  rk1,
    input  logic [4:0]  rd0,
    input  logic [4:0]  rd1,
    input  logic        use_rj0,
    input  logic        use_rj1,
    input  logic        use_rk0,
    input  logic        use_rk1,
    input  logic        use_rd0,
    input  logic        use_rd1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  lat0,
    input  logic [1:0]  lat1,
    input  logic        div_done,
    input  logic [4:0]  div_rd,
    output logic        stall,
    output logic        issue1_ok,
    output logic        fire0,
    output logic        fire1,
    output logic [31:0] busy_vec
);

    logic [NUM_REGS-1:0] busy;
    logic                hazard0;
    logic                hazard1;
    logic                pair_conflict;

    assign busy[0] = 1'b0;

    assign hazard0 = valid0 && (src_busy(use_rj0, rj0, busy) ||
                                src_busy(use_rk0, rk0, busy) ||
                                src_busy(use_rd0, rd0, busy));
    assign hazard1 = valid1 && (src_busy(use_rj1, rj1, busy) ||
                                src_busy(use_rk1, rk1, busy) ||
                                src_busy(use_rd1, rd1, busy));

    // An ALU result reaches lane1 through the bypass, so only non-ALU producers split the pair.
    assign pair_conflict =
        (we0 && (rd0 != 5'd0) && (lat0 != CLS_ALU) &&
         (reads_reg(use_rj1, rj1, rd0) || reads_reg(use_rk1, rk1, rd0) ||
          reads_reg(use_rd1, rd1, rd0))) ||
        (is_muldiv(lat0) && is_muldiv(lat1));

    assign stall     = valid0 && (hazard0 || pipe_stall);
    assign issue1_ok = valid1 && !stall && !hazard1 && !pair_conflict;
    assign fire0     = valid0 && !stall;
    assign fire1     = fire0 && issue1_ok;
    assign busy_vec  = busy;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic             hit0;
        logic             hit1;
        logic [1:0]       sel_lat;
        logic [CNT_W-1:0] sel_cnt;

        assign hit0    = fire0 && we0 && (rd0 == 5'(r));
        assign hit1    = fire1 && we1 && (rd1 == 5'(r));
        // lane1 is the younger instruction, so it owns rd when both lanes write it.
        assign sel_lat = hit1 ? lat1 : lat0;
        assign sel_cnt = (sel_lat == CLS_MUL) ? CNT_W'(LAT_MUL) : CNT_W'(LAT_LOAD);

        sb_entry #(.CNT_W(CNT_W)) u_entry (
            .clk     (clk),
            .rstn    (rstn),
            .flush   (flush),
            .wr_en   (hit0 || hit1),
            .wr_busy (sel_lat != CLS_ALU),
            .wr_long (sel_lat == CLS_DIV),
            .wr_cnt  (sel_cnt),
            .dec_en  (!pipe_stall),
            .div_clr (div_done && (div_rd == 5'(r))),
            .busy    (busy[r])
        );
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush, pipe_stall;
    logic        valid0, valid1;
    logic [4:0]  rj0, rj1, rk0, rk1, rd0, rd1;
    logic        use_rj0, use_rj1, use_rk0, use_rk1, use_rd0, use_rd1;
    logic        we0, we1;
    logic [1:0]  lat0, lat1;
    logic        div_done;
    logic [4:0]  div_rd;
    logic        stall, issue1_ok, fire0, fire1;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    issue_scoreboard dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .pipe_stall (pipe_stall),
        .valid0     (valid0),
        .valid1     (valid1),
        .rj0        (rj0),
        .rj1        (rj1),
        .rk0        (rk0),
        .rk1        (rk1),
        .rd0        (rd0),
        .rd1        (rd1),
        .use_rj0    (use_rj0),
        .use_rj1    (use_rj1),
        .use_rk0    (use_rk0),
        .use_rk1    (use_rk1),
        .use_rd0    (use_rd0),
        .use_rd1    (use_rd1),
        .we0        (we0),
        .we1        (we1),
        .lat0       (lat0),
        .lat1       (lat1),
        .div_done   (div_done),
        .div_rd     (div_rd),
        .stall      (stall),
        .issue1_ok  (issue1_ok),
        .fire0      (fire0),
        .fire1      (fire1),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic idle();
        flush = 0; pipe_stall = 0; div_done = 0; div_rd = 0;
        valid0 = 0; rj0 = 0; rk0 = 0; rd0 = 0; use_rj0 = 0; use_rk0 = 0; use_rd0 = 0;
        we0 = 0; lat0 = 0;
        valid1 = 0; rj1 = 0; rk1 = 0; rd1 = 0; use_rj1 = 0; use_rk1 = 0; use_rd1 = 0;
        we1 = 0; lat1 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rstn = 0; valid0 = 1;
        step(); step();
        rstn = 1;
        settle();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", busy_vec, 32'h0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (fire0 !== 1'b1) begin errors++; $display("FAIL reset_fire0 got %b exp 1", fire0); end
        step(); idle(); settle();
    endtask

    task automatic test_load_use();
        valid0 = 1; we0 = 1; rd0 = 5; lat0 = 2'd1;
        settle();
        checks++; if (fire0 !== 1'b1) begin errors++; $display("FAIL lu_load_fire got %b exp 1", fire0); end
        step();
        idle(); valid0 = 1; we0 = 1; rd0 = 6; rj0 = 5; use_rj0 = 1; rk0 = 7; use_rk0 = 1;
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
        checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL lu_busy5 got %b exp 1", busy_vec[5]); end
        step(); settle();
        checks++; if (fire0 !== 1'b1) begin errors++; $display("FAIL lu_issue got %b exp 1", fire0); end
        checks++; if (busy_vec[5] !== 1'b0) begin errors++; $display("FAIL lu_busy5_clr got %b exp 0", busy_vec[5]); end
        step(); idle(); settle();
    endtask

    task automatic test_pair_split();
        // LOAD r3 then reader of r3 in lane1
        valid0 = 1; we0 = 1; rd0 = 3; lat0 = 2'd1;
        valid1 = 1; rj1 = 3; use_rj1 = 1; we1 = 1; rd1 = 4;
        settle();
        checks++; if (fire0 !== 1'b1) begin errors++; $display("FAIL ps_load_fire0 got %b exp 1", fire0); end
        checks++; if (issue1_ok !== 1'b0) begin errors++; $display("FAIL ps_load_ok1 got %b exp 0", issue1_ok); end
        step(); idle(); step(); settle();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL ps_load_drain got %h exp 0", busy_vec); end
        // ALU r3 then reader of r3: bypass covers it
        valid0 = 1; we0 = 1; rd0 = 3; lat0 = 2'd0;
        valid1 = 1; rk1 = 3; use_rk1 = 1; we1 = 1; rd1 = 4;
        settle();
        checks++; if (fire1 !== 1'b1) begin errors++; $display("FAIL ps_alu_fire1 got %b exp 1", fire1); end
        step(); idle();
        // MUL + DIV share one unit
        valid0 = 1; we0 = 1; rd0 = 10; lat0 = 2'd2;
        valid1 = 1; we1 = 1; rd1 = 11; lat1 = 2'd3;
        settle();
        checks++; if (issue1_ok !== 1'b0) begin errors++; $display("FAIL ps_muldiv_ok1 got %b exp 0", issue1_ok); end
        checks++; if (fire0 !== 1'b1) begin errors++; $display("FAIL ps_muldiv_fire0 got %b exp 1", fire0); end
        step(); idle(); settle();
        checks++; if (busy_vec !== 32'h0000_0400) begin errors++; $display("FAIL ps_mul_only got %h exp %h", busy_vec, 32'h0000_0400); end
        step(); step(); settle();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL ps_mul_drain got %h exp 0", busy_vec); end
    endtask

    task automatic test_divide();
        int held;
        valid0 = 1; we0 = 1; rd0 = 9; lat0 = 2'd3;
        step(); idle();
        valid0 = 1; rj0 = 9; use_rj0 = 1; we0 = 1; rd0 = 12;
        held = 0;
        for (int i = 0; i < 19; i++) begin
            settle();
            if (stall === 1'b1) held++;
            step();
        end
        checks++; if (held !== 19) begin errors++; $display("FAIL div_hold got %0d exp 19", held); end
        div_done = 1; div_rd = 9;
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL div_done_cycle got %b exp 1", stall); end
        step(); div_done = 0; div_rd = 0;
        settle();
        checks++; if (fire0 !== 1'b1) begin errors++; $display("FAIL div_reader_fire got %b exp 1", fire0); end
        step(); idle(); settle();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL div_drain got %h exp 0", busy_vec); end
    endtask

    task automatic test_pipe_stall();
        valid0 = 1; we0 = 1; rd0 = 4; lat0 = 2'd2;
        step(); idle();
        pipe_stall = 1; valid0 = 1;
        settle();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL psf_stall got %b exp 1", stall); end
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (busy_vec[4] !== 1'b1) begin errors++; $display("FAIL psf_frozen%0d got %b exp 1", i, busy_vec[4]); end
            step();
        end
        idle(); settle();
        checks++; if (busy_vec[4] !== 1'b1) begin errors++; $display("FAIL psf_run1 got %b exp 1", busy_vec[4]); end
        step(); settle();
        checks++; if (busy_vec[4] !== 1'b1) begin errors++; $display("FAIL psf_run2 got %b exp 1", busy_vec[4]); end
        step(); settle();
        checks++; if (busy_vec[4] !== 1'b0) begin errors++; $display("FAIL psf_clear got %b exp 0", busy_vec[4]); end
    endtask

    task automatic test_flush();
        valid0 = 1; we0 = 1; rd0 = 8; lat0 = 2'd1;
        valid1 = 1; we1 = 1; rd1 = 12; lat1 = 2'd3;
        step(); idle();
        flush = 1; pipe_stall = 1;
        settle();
        checks++; if (busy_vec !== 32'h0000_1100) begin errors++; $display("FAIL fl_pending got %h exp %h", busy_vec, 32'h0000_1100); end
        step(); idle(); settle();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL fl_cleared got %h exp 0", busy_vec); end
        // flush outranks a same-edge allocate
        flush = 1; valid0 = 1; we0 = 1; rd0 = 8; lat0 = 2'd3;
        step(); idle(); settle();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL fl_vs_alloc got %h exp 0", busy_vec); end
    endtask

    task automatic test_same_edge();
        valid0 = 1; we0 = 1; rd0 = 8; lat0 = 2'd1;
        valid1 = 1; we1 = 1; rd1 = 8; lat1 = 2'd1;
        settle();
        checks++; if (fire1 !== 1'b1) begin errors++; $display("FAIL se_ll_fire1 got %b exp 1", fire1); end
        step(); idle(); settle();
        checks++; if (busy_vec !== 32'h0000_0100) begin errors++; $display("FAIL se_ll_busy got %h exp %h", busy_vec, 32'h0000_0100); end
        step(); settle();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL se_ll_drain got %h exp 0", busy_vec); end
        // lane0 DIV r8, lane1 LOAD r8: lane1's short entry wins
        valid0 = 1; we0 = 1; rd0 = 8; lat0 = 2'd3;
        valid1 = 1; we1 = 1; rd1 = 8; lat1 = 2'd1;
        step(); idle(); step(); settle();
        checks++; if (busy_vec[8] !== 1'b0) begin errors++; $display("FAIL se_own_lane1 got %b exp 0", busy_vec[8]); end
        // lane0 LOAD r8, lane1 ALU r8: newer ALU write leaves rd free
        valid0 = 1; we0 = 1; rd0 = 8; lat0 = 2'd1;
        valid1 = 1; we1 = 1; rd1 = 8; lat1 = 2'd0;
        step(); idle(); settle();
        checks++; if (busy_vec[8] !== 1'b0) begin errors++; $display("FAIL se_waw_alu got %b exp 0", busy_vec[8]); end
        // div_done r9 on the same edge as a new DIV r9
        valid0 = 1; we0 = 1; rd0 = 9; lat0 = 2'd3;
        step(); idle();
        valid0 = 1; we0 = 1; rd0 = 9; lat0 = 2'd3; div_done = 1; div_rd = 9;
        step(); idle(); settle();
        checks++; if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL se_div_realloc got %b exp 1", busy_vec[9]); end
        div_done = 1; div_rd = 9;
        step(); idle(); settle();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL se_div_final got %h exp 0", busy_vec); end
    endtask

    initial begin
        rstn = 0;
        idle();
        test_reset();
        test_load_use();
        test_pair_split();
        test_divide();
        test_pipe_stall();
        test_flush();
        test_same_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
